// File: rtl/matrix_operand_loader_if.sv
// Element stream in, packed 4x4 operand out, between the loader and its neighbours.
// The slave view belongs to the loader; the master view belongs to whatever drives it.
interface matrix_operand_loader_if;
  logic [15:0]  elemIn;
  logic         elemValid;
  logic         elemReady;
  logic [255:0] matOut;
  logic         matValid;
  logic         matSel;
  logic         matReady;

  modport slave (
    input  elemIn, elemValid, matReady,
    output elemReady, matOut, matValid, matSel
  );

  modport master (
    output elemIn, elemValid, matReady,
    input  elemReady, matOut, matValid, matSel
  );
endinterface

// File: rtl/matrix_operand_loader.sv
// Packs a row-major stream of 16-bit elements into double-buffered 4x4 operands A and B
// and presents them alternately (A, B, A, B, ...) to the matrix multiplier.
module matrix_operand_loader (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     flush,
  matrix_operand_loader_if.slave   bus
);

  logic [4:0]   elemCnt;
  logic         aFull;
  logic         bFull;
  logic         sendSel;
  logic [255:0] packA;
  logic [255:0] packB;
  logic         accept;
  logic         transfer;

  // elemCnt[4] selects the buffer being filled; ready depends only on that buffer's flag.
  assign bus.elemReady = elemCnt[4] ? !bFull : !aFull;
  assign accept        = bus.elemValid & bus.elemReady;

  assign bus.matValid  = sendSel ? bFull : aFull;
  assign bus.matSel    = sendSel;
  assign bus.matOut    = sendSel ? packB : packA;
  assign transfer      = bus.matValid & bus.matReady;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : gSlot
      logic [15:0] slotA;
      logic [15:0] slotB;
      logic        slotHit;

      assign slotHit = accept && !flush && (elemCnt[3:0] == 4'(gi));

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          slotA <= '0;
          slotB <= '0;
        end else if (slotHit) begin
          if (elemCnt[4]) slotB <= bus.elemIn;
          else            slotA <= bus.elemIn;
        end
      end

      assign packA[16*gi +: 16] = slotA;
      assign packB[16*gi +: 16] = slotB;
    end
  endgenerate

  // A set and a clear never hit the same flag in one cycle: set needs !full, clear needs full.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      elemCnt <= '0;
      aFull   <= 1'b0;
      bFull   <= 1'b0;
      sendSel <= 1'b0;
    end else if (flush) begin
      elemCnt <= '0;
      aFull   <= 1'b0;
      bFull   <= 1'b0;
      sendSel <= 1'b0;
    end else begin
      if (accept) begin
        elemCnt <= elemCnt + 5'd1;
        if (elemCnt == 5'd15) aFull <= 1'b1;
        if (elemCnt == 5'd31) bFull <= 1'b1;
      end
      if (transfer) begin
        if (sendSel) bFull <= 1'b0;
        else         aFull <= 1'b0;
        sendSel <= !sendSel;
      end
    end
  end

endmodule
